// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU-op and memory-size encodings plus the
// per-stage control bundles of the pipelined control unit.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_LWU   = 6'b100111;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    ALU_FUNCT = 4'd0,
    ALU_ADD   = 4'd1,
    ALU_ADDU  = 4'd2,
    ALU_SUB   = 4'd3,
    ALU_SLT   = 4'd4,
    ALU_SLTU  = 4'd5,
    ALU_AND   = 4'd6,
    ALU_OR    = 4'd7,
    ALU_XOR   = 4'd8,
    ALU_LUI   = 4'd9
  } aluop_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic aluSrc;
    logic regDst;
    logic branch;
    logic bne;
    logic jump;
  } ex_t;

  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic       memUnsigned;
    logic [1:0] memSize;
  } mem_t;

  typedef struct packed {
    logic regWrite;
    logic memtoReg;
    logic link;
  } wb_t;

  typedef struct packed {
    ex_t  ex;
    mem_t mem;
    wb_t  wb;
  } ctrl_t;

  // Low opcode bits 00/01/11 select byte/half/word.
  function automatic logic [1:0] memSizeOf(
    input logic [1:0] lo
  );
    return (lo == 2'b11) ? SZ_WORD : lo;
  endfunction

  function automatic aluop_e immAluOp(
    input logic [2:0] f
  );
    unique case (f)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_ADDU;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_AND;
      3'd5:    return ALU_OR;
      3'd6:    return ALU_XOR;
      default: return ALU_LUI;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder producing the control bundle,
// the ALU operation and an undefined-opcode flag.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W    = 5,
  parameter bit EN_JUMP    = 1'b1,
  parameter bit EN_SUBWORD = 1'b1
) (
  input  logic [5:0]         opcode,
  output ctrl_t              ctrl,
  output logic [ALUOP_W-1:0] aluOp,
  output logic               illegal
);

  aluop_e op;

  always_comb begin
    ctrl    = '0;
    op      = ALU_FUNCT;
    illegal = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl.ex.regDst   = 1'b1;
        ctrl.wb.regWrite = 1'b1;
      end
      OP_LB, OP_LH, OP_LW,
      OP_LBU, OP_LHU, OP_LWU: begin
        ctrl.ex.aluSrc      = 1'b1;
        ctrl.mem.memRead    = 1'b1;
        ctrl.mem.memSize    = memSizeOf(opcode[1:0]);
        ctrl.mem.memUnsigned = opcode[2];
        ctrl.wb.regWrite    = 1'b1;
        ctrl.wb.memtoReg    = 1'b1;
        op = ALU_ADD;
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl.ex.aluSrc    = 1'b1;
        ctrl.mem.memWrite = 1'b1;
        ctrl.mem.memSize  = memSizeOf(opcode[1:0]);
        op = ALU_ADD;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.ex.aluSrc   = 1'b1;
        ctrl.wb.regWrite = 1'b1;
        op = immAluOp(opcode[2:0]);
      end
      OP_BEQ, OP_BNE: begin
        ctrl.ex.branch = 1'b1;
        ctrl.ex.bne    = opcode[0];
        op = ALU_SUB;
      end
      OP_J, OP_JAL: begin
        if (EN_JUMP) begin
          ctrl.ex.jump     = 1'b1;
          ctrl.wb.regWrite = opcode[0];
          ctrl.wb.link     = opcode[0];
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
    // Without sub-word support every access is a signed word.
    if (!EN_SUBWORD &&
        (ctrl.mem.memRead || ctrl.mem.memWrite)) begin
      ctrl.mem.memSize     = SZ_WORD;
      ctrl.mem.memUnsigned = 1'b0;
    end
  end

  assign aluOp = ALUOP_W'(op);

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: decode in ID, ID/EX, EX/MEM and
// MEM/WB control registers, load-use stall and bubble insertion.
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W    = 5,
  parameter int RADDR_W    = 5,
  parameter bit EN_JUMP    = 1'b1,
  parameter bit EN_SUBWORD = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [5:0]         id_opcode,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic               flush,
  output logic               stall,
  output logic               ex_ALUSrc,
  output logic               ex_RegDst,
  output logic               ex_branch,
  output logic               ex_bne,
  output logic               ex_jump,
  output logic [ALUOP_W-1:0] ex_AluOp,
  output logic               mem_MemRead,
  output logic               mem_MemWrite,
  output logic               mem_unsigned,
  output logic [1:0]         mem_size,
  output logic               wb_RegWrite,
  output logic               wb_MemtoReg,
  output logic               wb_link,
  output logic               illegal
);

  ctrl_t              dec;
  logic [ALUOP_W-1:0] decAluOp;
  logic               decIllegal;

  ctrl_decode #(
    .ALUOP_W   (ALUOP_W),
    .EN_JUMP   (EN_JUMP),
    .EN_SUBWORD(EN_SUBWORD)
  ) uDecode (
    .opcode (id_opcode),
    .ctrl   (dec),
    .aluOp  (decAluOp),
    .illegal(decIllegal)
  );

  ctrl_t              idEx;
  logic [ALUOP_W-1:0] idExAluOp;
  logic [RADDR_W-1:0] idExRt;
  mem_t               exMemMem;
  wb_t                exMemWb;
  wb_t                memWbWb;
  logic               illegalQ;
  logic               useHit;
  logic               issue;

  assign useHit = idEx.mem.memRead && id_valid &&
                  (idExRt == id_rs || idExRt == id_rt);
  // A flushed ID slot is dropped anyway, so it never stalls.
  assign stall  = useHit && !flush;
  assign issue  = id_valid && !flush && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idEx      <= '0;
      idExAluOp <= '0;
      idExRt    <= '0;
      exMemMem  <= '0;
      exMemWb   <= '0;
      memWbWb   <= '0;
      illegalQ  <= 1'b0;
    end else begin
      if (issue) begin
        idEx      <= dec;
        idExAluOp <= decAluOp;
        idExRt    <= id_rt;
      end else begin
        idEx      <= '0;
        idExAluOp <= '0;
        idExRt    <= '0;
      end
      exMemMem <= idEx.mem;
      exMemWb  <= idEx.wb;
      memWbWb  <= exMemWb;
      if (id_valid && decIllegal) illegalQ <= 1'b1;
    end
  end

  assign ex_ALUSrc    = idEx.ex.aluSrc;
  assign ex_RegDst    = idEx.ex.regDst;
  assign ex_branch    = idEx.ex.branch;
  assign ex_bne       = idEx.ex.bne;
  assign ex_jump      = idEx.ex.jump;
  assign ex_AluOp     = idExAluOp;
  assign mem_MemRead  = exMemMem.memRead;
  assign mem_MemWrite = exMemMem.memWrite;
  assign mem_unsigned = exMemMem.memUnsigned;
  assign mem_size     = exMemMem.memSize;
  assign wb_RegWrite  = memWbWb.regWrite;
  assign wb_MemtoReg  = memWbWb.memtoReg;
  assign wb_link      = memWbWb.link;
  assign illegal      = illegalQ;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Scoreboard bench for ctrl_pipe_unit: default build plus a
// build without jump and sub-word support, driven in lockstep.
module tb_ctrl_pipe_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       id_valid = 1'b0;
  logic [5:0] id_opcode = '0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       flush = 1'b0;

  logic       stall, ex_ALUSrc, ex_RegDst, ex_branch, ex_bne, ex_jump;
  logic [4:0] ex_AluOp;
  logic       mem_MemRead, mem_MemWrite, mem_unsigned;
  logic [1:0] mem_size;
  logic       wb_RegWrite, wb_MemtoReg, wb_link, illegal;

  logic       d2Stall, d2AluSrc, d2RegDst, d2Branch, d2Bne, d2Jump;
  logic [4:0] d2AluOp;
  logic       d2MemRead, d2MemWrite, d2Unsigned;
  logic [1:0] d2Size;
  logic       d2RegWrite, d2MemtoReg, d2Link, d2Illegal;

  always #5 clk = ~clk;

  ctrl_pipe_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .flush(flush), .stall(stall),
    .ex_ALUSrc(ex_ALUSrc), .ex_RegDst(ex_RegDst),
    .ex_branch(ex_branch), .ex_bne(ex_bne), .ex_jump(ex_jump),
    .ex_AluOp(ex_AluOp),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_unsigned(mem_unsigned), .mem_size(mem_size),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
    .wb_link(wb_link), .illegal(illegal)
  );

  ctrl_pipe_unit #(
    .EN_JUMP(1'b0), .EN_SUBWORD(1'b0)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .flush(flush), .stall(d2Stall),
    .ex_ALUSrc(d2AluSrc), .ex_RegDst(d2RegDst),
    .ex_branch(d2Branch), .ex_bne(d2Bne), .ex_jump(d2Jump),
    .ex_AluOp(d2AluOp),
    .mem_MemRead(d2MemRead), .mem_MemWrite(d2MemWrite),
    .mem_unsigned(d2Unsigned), .mem_size(d2Size),
    .wb_RegWrite(d2RegWrite), .wb_MemtoReg(d2MemtoReg),
    .wb_link(d2Link), .illegal(d2Illegal)
  );

  // {ALUSrc,RegDst,branch,bne,jump,AluOp}
  localparam logic [9:0] EX_R   = 10'b01000_00000;
  localparam logic [9:0] EX_IMM = 10'b10000_00001;
  localparam logic [9:0] EX_BNE = 10'b00110_00011;
  localparam logic [9:0] EX_JAL = 10'b00001_00000;
  // {MemRead,MemWrite,unsigned,size}
  localparam logic [4:0] MEM_LW  = 5'b10010;
  localparam logic [4:0] MEM_LBU = 5'b10100;
  localparam logic [4:0] MEM_SW  = 5'b01010;
  // {RegWrite,MemtoReg,link}
  localparam logic [2:0] WB_R   = 3'b100;
  localparam logic [2:0] WB_LD  = 3'b110;
  localparam logic [2:0] WB_JAL = 3'b101;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] LBU  = 6'b100100;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JAL  = 6'b000011;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BAD  = 6'b111111;

  typedef struct {
    int          due;
    int          sel;
    logic [15:0] val;
  } exp_t;

  exp_t  sb[$];
  int    cyc = 0;
  int    nCmp = 0;
  int    nBad = 0;
  string names[7] = '{"stall", "ex", "mem", "wb", "illegal",
                      "mem_nosub", "illegal_nojump"};

  function automatic logic [15:0] act(input int s);
    case (s)
      0: return 16'(stall);
      1: return 16'({ex_ALUSrc, ex_RegDst, ex_branch,
                     ex_bne, ex_jump, ex_AluOp});
      2: return 16'({mem_MemRead, mem_MemWrite,
                     mem_unsigned, mem_size});
      3: return 16'({wb_RegWrite, wb_MemtoReg, wb_link});
      4: return 16'(illegal);
      5: return 16'({d2MemRead, d2MemWrite, d2Unsigned, d2Size});
      default: return 16'(d2Illegal);
    endcase
  endfunction

  task automatic chk(input string n, input logic [15:0] a,
                     input logic [15:0] e);
    nCmp++;
    if (a !== e) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)",
               n, a, e, cyc);
    end
  endtask

  task automatic push(input int due, input int sel,
                      input logic [15:0] v);
    exp_t e;
    e.due = due;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  // Monitor: every negedge, compare all expectations due now.
  always @(negedge clk) begin
    cyc++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        chk(names[sb[i].sel], act(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic step(
    input logic v, input logic [5:0] op,
    input logic [4:0] rs, input logic [4:0] rt,
    input logic fl, input logic st,
    input logic [9:0] ex, input logic [4:0] mem,
    input logic [2:0] wb, input logic ill,
    input logic [4:0] mem2, input logic ill2
  );
    @(posedge clk);
    #2;
    id_valid  = v;
    id_opcode = op;
    id_rs     = rs;
    id_rt     = rt;
    flush     = fl;
    push(cyc + 1, 0, 16'(st));
    push(cyc + 2, 1, 16'(ex));
    push(cyc + 3, 2, 16'(mem));
    push(cyc + 4, 3, 16'(wb));
    push(cyc + 2, 4, 16'(ill));
    push(cyc + 3, 5, 16'(mem2));
    push(cyc + 2, 6, 16'(ill2));
  endtask

  task automatic idle(input logic ill, input logic ill2);
    step(1'b0, RT, 5'd0, 5'd0, 1'b0, 1'b0,
         '0, '0, '0, ill, '0, ill2);
  endtask

  task automatic chkAllZero(input string tag);
    for (int s = 0; s < 7; s++)
      chk({tag, "_", names[s]}, act(s), 16'h0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chkAllZero("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    idle(0, 0);
    // lw rt=5 then R-type rs=5: one stall, bubble, then R-type
    step(1, LW,   5'd1, 5'd5, 0, 0, EX_IMM, MEM_LW, WB_LD, 0, MEM_LW, 0);
    step(1, RT,   5'd5, 5'd2, 0, 1, '0, '0, '0, 0, '0, 0);
    step(1, RT,   5'd5, 5'd2, 0, 0, EX_R, '0, WB_R, 0, '0, 0);
    // lw rt=5 then addi rs=3 rt=7: no hazard
    step(1, LW,   5'd0, 5'd5, 0, 0, EX_IMM, MEM_LW, WB_LD, 0, MEM_LW, 0);
    step(1, ADDI, 5'd3, 5'd7, 0, 0, EX_IMM, '0, WB_R, 0, '0, 0);
    // hazard coinciding with flush: no stall, bubble
    step(1, LW,   5'd0, 5'd6, 0, 0, EX_IMM, MEM_LW, WB_LD, 0, MEM_LW, 0);
    step(1, RT,   5'd6, 5'd1, 1, 0, '0, '0, '0, 0, '0, 0);
    step(1, ADDI, 5'd2, 5'd3, 0, 0, EX_IMM, '0, WB_R, 0, '0, 0);
    // lbu: byte unsigned; word signed without sub-word support
    step(1, LBU,  5'd1, 5'd8, 0, 0, EX_IMM, MEM_LBU, WB_LD, 0, MEM_LW, 0);
    // jal: illegal in the build without jumps, sticky
    step(1, JAL,  5'd0, 5'd0, 0, 0, EX_JAL, '0, WB_JAL, 0, '0, 1);
    step(1, BNE,  5'd1, 5'd2, 0, 0, EX_BNE, '0, '0, 0, '0, 1);
    step(1, SW,   5'd1, 5'd3, 0, 0, EX_IMM, MEM_SW, '0, 0, MEM_SW, 1);
    // register 0 hazards like any other register
    step(1, LW,   5'd1, 5'd0, 0, 0, EX_IMM, MEM_LW, WB_LD, 0, MEM_LW, 1);
    step(1, RT,   5'd0, 5'd4, 0, 1, '0, '0, '0, 0, '0, 1);
    step(1, RT,   5'd0, 5'd4, 0, 0, EX_R, '0, WB_R, 0, '0, 1);
    // undefined opcode
    step(1, BAD,  5'd0, 5'd0, 0, 0, '0, '0, '0, 1, '0, 1);
    step(0, BAD,  5'd0, 5'd0, 0, 0, '0, '0, '0, 1, '0, 1);
    idle(1, 1);
    idle(1, 1);
    // in-flight work discarded by an asynchronous reset
    step(1, LW,   5'd1, 5'd2, 0, 0, EX_IMM, MEM_LW, WB_LD, 1, MEM_LW, 1);
    step(1, ADDI, 5'd3, 5'd4, 0, 0, EX_IMM, '0, WB_R, 1, '0, 1);
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    id_valid = 1'b0;
    sb.delete();
    #1 chkAllZero("async_reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(0, 0);
    step(1, LW,   5'd1, 5'd2, 0, 0, EX_IMM, MEM_LW, WB_LD, 0, MEM_LW, 0);
    step(1, ADDI, 5'd3, 5'd4, 0, 0, EX_IMM, '0, WB_R, 0, '0, 0);
    repeat (4) idle(0, 0);
    repeat (5) @(negedge clk);
    #1 chk("scoreboard_drained", 16'(sb.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule
